// File: rtl/cpu_dbg_pkg.sv
// Shared encodings for the CPU run/debug sequencer.
package cpu_dbg_pkg;

    localparam int STATE_W        = 3;
    localparam int RST_CYCLES_DEF = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_HALTED  = 3'd0,
        ST_RUN     = 3'd1,
        ST_STEP    = 3'd2,
        ST_BREAK   = 3'd3,
        ST_HLTSTOP = 3'd4,
        ST_RSTSEQ  = 3'd5
    } run_state_e;

endpackage

// File: rtl/rise_det.sv
// Rising-edge detector; the history flop resets high so a level held through reset never fires.
module rise_det (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk) begin
        if (reset) prev <= 1'b1;
        else       prev <= level;
    end

    assign pulse = level & ~prev;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/debug sequencer: gates CPU advance (CE) for free run, counted step,
// PC breakpoint, halt-instruction stop and a timed CPU reset.
module cpu_run_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int RST_CYCLES = RST_CYCLES_DEF
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               RUN_REQ,
    input  logic               HALT_REQ,
    input  logic               STEP_REQ,
    input  logic               RST_REQ,
    input  logic [7:0]         STEP_CNT,
    input  logic               BP_EN,
    input  logic [7:0]         BP_ADDR,
    input  logic [7:0]         NextPC,
    input  logic               HALT_INST,
    output logic               CE,
    output logic               CPU_RST,
    output logic [STATE_W-1:0] STATE,
    output logic               BP_HIT,
    output logic [7:0]         STEPS_LEFT,
    output logic [CNT_W-1:0]   RETIRED
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    logic run_e, halt_e, step_e, rst_e;

    rise_det u_run  (.clk(CLK), .reset(RESET), .level(RUN_REQ),  .pulse(run_e));
    rise_det u_halt (.clk(CLK), .reset(RESET), .level(HALT_REQ), .pulse(halt_e));
    rise_det u_step (.clk(CLK), .reset(RESET), .level(STEP_REQ), .pulse(step_e));
    rise_det u_rst  (.clk(CLK), .reset(RESET), .level(RST_REQ),  .pulse(rst_e));

    run_state_e       state, nxt_state;
    logic [7:0]       steps_left, nxt_steps;
    logic [RC_W-1:0]  rst_cnt, nxt_rcnt;
    logic [CNT_W-1:0] retired, nxt_ret;
    logic             bp_skip, nxt_skip;
    logic             ce;

    assign ce = (state == ST_RUN) || (state == ST_STEP);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_HALTED;
            steps_left <= '0;
            rst_cnt    <= '0;
            retired    <= '0;
            bp_skip    <= 1'b0;
        end else begin
            state      <= nxt_state;
            steps_left <= nxt_steps;
            rst_cnt    <= nxt_rcnt;
            retired    <= nxt_ret;
            bp_skip    <= nxt_skip;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_steps = steps_left;
        nxt_rcnt  = rst_cnt;
        nxt_ret   = retired;
        nxt_skip  = bp_skip;
        // Any advancing cycle retires one instruction and consumes the breakpoint skip.
        if (ce) begin
            nxt_skip = 1'b0;
            if (retired != '1) nxt_ret = retired + CNT_W'(1);
        end
        if (rst_e) begin
            nxt_state = ST_RSTSEQ;
            nxt_ret   = '0;
            nxt_steps = '0;
            nxt_skip  = 1'b0;
            nxt_rcnt  = RC_W'(RST_CYCLES - 1);
        end else begin
            case (state)
                ST_HALTED, ST_BREAK: begin
                    if (!halt_e) begin
                        if (step_e) begin
                            nxt_state = ST_STEP;
                            nxt_steps = (STEP_CNT == 8'd0) ? 8'd1 : STEP_CNT;
                        end else if (run_e) begin
                            nxt_state = ST_RUN;
                        end
                        // Leaving a breakpoint must execute the instruction it stopped on.
                        if ((step_e || run_e) && state == ST_BREAK) nxt_skip = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (halt_e)                                          nxt_state = ST_HALTED;
                    else if (HALT_INST)                                  nxt_state = ST_HLTSTOP;
                    else if (BP_EN && NextPC == BP_ADDR && !bp_skip)     nxt_state = ST_BREAK;
                end
                ST_STEP: begin
                    nxt_steps = steps_left - 8'd1;
                    if (halt_e)                  nxt_state = ST_HALTED;
                    else if (HALT_INST)          nxt_state = ST_HLTSTOP;
                    else if (steps_left == 8'd1) nxt_state = ST_HALTED;
                end
                ST_HLTSTOP: ;
                ST_RSTSEQ: begin
                    if (rst_cnt == '0) nxt_state = ST_HALTED;
                    else               nxt_rcnt  = rst_cnt - RC_W'(1);
                end
                default: nxt_state = ST_HALTED;
            endcase
        end
    end

    assign CE         = ce;
    assign CPU_RST    = (state == ST_RSTSEQ);
    assign STATE      = state;
    assign BP_HIT     = (state == ST_BREAK);
    assign STEPS_LEFT = steps_left;
    assign RETIRED    = retired;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: a behavioural model predicts every cycle's
// outputs; a negedge monitor compares. A CNT_W=4 twin checks counter saturation.
module tb_cpu_run_ctrl;

    logic       CLK = 1'b0;
    logic       RESET, RUN_REQ, HALT_REQ, STEP_REQ, RST_REQ, BP_EN, HALT_INST;
    logic [7:0] STEP_CNT, BP_ADDR, NextPC;

    logic        ce16, crst16, bp16, ce4, crst4, bp4;
    logic [2:0]  st16, st4;
    logic [7:0]  sl16, sl4;
    logic [15:0] ret16;
    logic [3:0]  ret4;

    always #5 CLK = ~CLK;

    cpu_run_ctrl u16 (
        .CLK(CLK), .RESET(RESET), .RUN_REQ(RUN_REQ), .HALT_REQ(HALT_REQ),
        .STEP_REQ(STEP_REQ), .RST_REQ(RST_REQ), .STEP_CNT(STEP_CNT), .BP_EN(BP_EN),
        .BP_ADDR(BP_ADDR), .NextPC(NextPC), .HALT_INST(HALT_INST), .CE(ce16),
        .CPU_RST(crst16), .STATE(st16), .BP_HIT(bp16), .STEPS_LEFT(sl16), .RETIRED(ret16)
    );

    cpu_run_ctrl #(.CNT_W(4)) u4 (
        .CLK(CLK), .RESET(RESET), .RUN_REQ(RUN_REQ), .HALT_REQ(HALT_REQ),
        .STEP_REQ(STEP_REQ), .RST_REQ(RST_REQ), .STEP_CNT(STEP_CNT), .BP_EN(BP_EN),
        .BP_ADDR(BP_ADDR), .NextPC(NextPC), .HALT_INST(HALT_INST), .CE(ce4),
        .CPU_RST(crst4), .STATE(st4), .BP_HIT(bp4), .STEPS_LEFT(sl4), .RETIRED(ret4)
    );

    localparam int M_HALTED = 0, M_RUN = 1, M_STEP = 2, M_BREAK = 3, M_HLTSTOP = 4, M_RSTSEQ = 5;
    localparam int M_RST_CYCLES = 2;

    typedef struct {
        int st;
        bit ce;
        bit crst;
        bit bp;
        int steps;
        int ret;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Model state: mode, remaining steps, unbounded retire count, reset cycles left.
    int       m_st, m_steps, m_ret, m_rleft;
    bit       m_skip;
    bit [3:0] m_prev;

    task automatic model_reset();
        m_st = M_HALTED; m_steps = 0; m_ret = 0; m_rleft = 0; m_skip = 0; m_prev = 4'hF;
    endtask

    task automatic model_step();
        bit eu, eh, es, er, adv, skip_was;
        if (RESET) begin
            model_reset();
            return;
        end
        eu = RUN_REQ  && !m_prev[0];
        eh = HALT_REQ && !m_prev[1];
        es = STEP_REQ && !m_prev[2];
        er = RST_REQ  && !m_prev[3];
        m_prev   = {RST_REQ, STEP_REQ, HALT_REQ, RUN_REQ};
        adv      = (m_st == M_RUN) || (m_st == M_STEP);
        skip_was = m_skip;
        if (adv) begin
            m_ret++;
            m_skip = 0;
        end
        if (er) begin
            m_st = M_RSTSEQ; m_ret = 0; m_steps = 0; m_skip = 0; m_rleft = M_RST_CYCLES;
        end else if (m_st == M_HALTED || m_st == M_BREAK) begin
            if (!eh && (es || eu)) begin
                if (m_st == M_BREAK) m_skip = 1;
                if (es) begin
                    m_st = M_STEP;
                    m_steps = (STEP_CNT == 0) ? 1 : int'(STEP_CNT);
                end else begin
                    m_st = M_RUN;
                end
            end
        end else if (m_st == M_RUN) begin
            if (eh) m_st = M_HALTED;
            else if (HALT_INST) m_st = M_HLTSTOP;
            else if (BP_EN && NextPC == BP_ADDR && !skip_was) m_st = M_BREAK;
        end else if (m_st == M_STEP) begin
            m_steps--;
            if (eh) m_st = M_HALTED;
            else if (HALT_INST) m_st = M_HLTSTOP;
            else if (m_steps == 0) m_st = M_HALTED;
        end else if (m_st == M_RSTSEQ) begin
            m_rleft--;
            if (m_rleft == 0) m_st = M_HALTED;
        end
    endtask

    // Push this cycle's prediction, then advance the model across the coming edge.
    task automatic tick();
        exp_t e;
        e.st = m_st;
        e.ce = (m_st == M_RUN) || (m_st == M_STEP);
        e.crst = (m_st == M_RSTSEQ);
        e.bp = (m_st == M_BREAK);
        e.steps = m_steps;
        e.ret = m_ret;
        sb.push_back(e);
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            int r16, r4;
            e = sb.pop_front();
            r16 = (e.ret > 65535) ? 65535 : e.ret;
            r4  = (e.ret > 15) ? 15 : e.ret;
            tests++;
            if (int'(st16) != e.st || ce16 != e.ce || crst16 != e.crst || bp16 != e.bp ||
                int'(sl16) != e.steps || int'(ret16) != r16) begin
                fails++;
                $display("FAIL outputs @%0t: got st=%0d ce=%0b cpu_rst=%0b bp=%0b steps=%0d ret=%0d, want st=%0d ce=%0b cpu_rst=%0b bp=%0b steps=%0d ret=%0d",
                         $time, st16, ce16, crst16, bp16, sl16, ret16,
                         e.st, e.ce, e.crst, e.bp, e.steps, r16);
            end
            tests++;
            if (int'(ret4) != r4 || ce4 != e.ce) begin
                fails++;
                $display("FAIL sat4 @%0t: got ret=%0d ce=%0b, want ret=%0d ce=%0b",
                         $time, ret4, ce4, r4, e.ce);
            end
        end
    end

    initial begin
        RESET = 1'b1; RUN_REQ = 1'b1; HALT_REQ = 1'b0; STEP_REQ = 1'b0; RST_REQ = 1'b0;
        STEP_CNT = 8'd0; BP_EN = 1'b0; BP_ADDR = 8'h0A; NextPC = 8'h00; HALT_INST = 1'b0;
        model_reset();
        @(posedge CLK);
        #1;
        ticks(3);
        RESET = 1'b0;
        ticks(3);                                      // held RUN_REQ must not fire
        RUN_REQ = 1'b0; tick();
        RUN_REQ = 1'b1; ticks(4);

        HALT_REQ = 1'b1; tick(); HALT_REQ = 1'b0; RUN_REQ = 1'b0; ticks(2);
        STEP_CNT = 8'd3; STEP_REQ = 1'b1; tick(); STEP_REQ = 1'b0; ticks(5);
        STEP_CNT = 8'd0; STEP_REQ = 1'b1; tick(); STEP_REQ = 1'b0; ticks(3);

        // Breakpoint at 0x0A, resume without re-break, then re-break later.
        BP_EN = 1'b1; BP_ADDR = 8'h0A; NextPC = 8'h02;
        RUN_REQ = 1'b1; tick(); RUN_REQ = 1'b0;
        for (int pc = 2; pc <= 10; pc += 2) begin NextPC = 8'(pc); tick(); end
        ticks(2);
        RUN_REQ = 1'b1; tick(); RUN_REQ = 1'b0;
        NextPC = 8'h0A; tick();
        NextPC = 8'h0C; tick();
        NextPC = 8'h0E; tick();
        NextPC = 8'h0A; ticks(3);
        BP_EN = 1'b0;

        RUN_REQ = 1'b1; tick(); RUN_REQ = 1'b0; ticks(2);
        HALT_INST = 1'b1; tick(); HALT_INST = 1'b0; ticks(2);
        RUN_REQ = 1'b1; tick(); RUN_REQ = 1'b0; tick();
        STEP_CNT = 8'd2; STEP_REQ = 1'b1; tick(); STEP_REQ = 1'b0; tick();
        RST_REQ = 1'b1; tick(); RST_REQ = 1'b0; ticks(4);

        RUN_REQ = 1'b1; tick(); RUN_REQ = 1'b0; ticks(2);
        STEP_CNT = 8'd5; HALT_REQ = 1'b1; STEP_REQ = 1'b1; tick();
        HALT_REQ = 1'b0; STEP_REQ = 1'b0; ticks(2);
        RUN_REQ = 1'b1; RST_REQ = 1'b1; tick(); RUN_REQ = 1'b0; RST_REQ = 1'b0; ticks(4);

        RUN_REQ = 1'b1; tick(); RUN_REQ = 1'b0; ticks(20);   // 4-bit twin saturates
        HALT_REQ = 1'b1; tick(); HALT_REQ = 1'b0; tick();
        STEP_CNT = 8'd6; STEP_REQ = 1'b1; tick(); STEP_REQ = 1'b0; ticks(2);
        RESET = 1'b1; tick(); RESET = 1'b0; ticks(3);

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 7) == 0) RUN_REQ  = ~RUN_REQ;
            if ($urandom_range(0, 15) == 0) HALT_REQ = ~HALT_REQ;
            if ($urandom_range(0, 9) == 0) STEP_REQ = ~STEP_REQ;
            if ($urandom_range(0, 59) == 0) RST_REQ  = ~RST_REQ;
            if ($urandom_range(0, 19) == 0) BP_EN    = ~BP_EN;
            STEP_CNT  = 8'($urandom_range(0, 6));
            BP_ADDR   = 8'($urandom_range(0, 7));
            NextPC    = 8'($urandom_range(0, 7));
            HALT_INST = ($urandom_range(0, 59) == 0);
            RESET     = ($urandom_range(0, 299) == 0);
            tick();
        end

        RESET = 1'b0; RUN_REQ = 1'b0; HALT_REQ = 1'b0; STEP_REQ = 1'b0; RST_REQ = 1'b0;
        HALT_INST = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge CLK);
        if (sb.size() > 0) begin
            fails++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
